gru_seq_ctrl: RTL
=================

# gru_seq_ctrl

Sequencer for the GRU tagging pipeline. It accepts one input-feature vector per timestep over a valid/ready stream and runs the shared GRU cell once per timestep, SEQ_LEN times. It controls the hidden-state register (clear on step 0, load after each step), then triggers the dense/ReLU/output head once per sequence and holds the result-valid flag until the consumer takes it. It owns sequencing only; the GRU cell, the h_t_minus_1 storage and the dense head sit outside it.

## Interface
- SEQ_LEN, 15: timesteps per sequence (≥2).
- X_SIZE, 6: elements per input vector.
- WIDTH, 4: element width (signed fixed point).
- TIMEOUT, 1023: maximum wait in cycles for cell_done or head_done (used only with the timeout feature).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- x_valid  in  1  input vector valid.
- x_data  in  X_SIZE×WIDTH signed  input vector (unpacked array [0:X_SIZE-1]).
- x_ready  out  1  block can accept a vector.
- cell_x  out  X_SIZE×WIDTH signed  registered vector driven to the GRU cell.
- cell_start  out  1  one-cycle pulse; the cell samples cell_x and h_t_minus_1.
- cell_done  in  1  one-cycle pulse; h_t is valid.
- h_clear  out  1  one-cycle pulse; zero h_t_minus_1 (step 0 only).
- h_load  out  1  one-cycle pulse; h_t_minus_1 <= h_t.
- head_start  out  1  one-cycle pulse; the head samples the final h_t.
- head_done  in  1  one-cycle pulse; head output is valid.
- out_valid  out  1  sequence result valid.
- out_ready  in  1  consumer accepts the result.
- step_idx  out  $clog2(SEQ_LEN)  current timestep.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag (0 when the timeout feature is compiled out).

## Operation
- States: IDLE, START, WAIT_CELL, LOAD_H, ACCEPT, HEAD, WAIT_HEAD, DONE.
- IDLE: x_ready=1. If x_valid, capture x_data into cell_x, set step_idx=0, assert h_clear in the same cycle, then go to START.
- START: cell_start=1 for one cycle, then WAIT_CELL.
- WAIT_CELL: wait for cell_done, then go to LOAD_H.
- LOAD_H: h_load=1 for one cycle.
  - If step_idx==SEQ_LEN-1, go to HEAD.
  - Otherwise increment step_idx and go to ACCEPT.
- ACCEPT: x_ready=1. If x_valid, capture the vector and go to START. Otherwise stall indefinitely, holding h_t_minus_1.
- HEAD: head_start=1 for one cycle, then WAIT_HEAD.
- WAIT_HEAD: wait for head_done, then go to DONE.
- DONE: out_valid=1. If out_ready, go to IDLE with step_idx=0.
- cell_x changes only on an accepted handshake. It is stable from the START cycle until the next acceptance.
- cell_done outside WAIT_CELL and head_done outside WAIT_HEAD are ignored.
- x_ready=0 in all states other than IDLE and ACCEPT; x_valid there is not consumed.
- step_idx saturates at SEQ_LEN-1; no wrap inside a sequence.

## Timing
- Reset values: x_ready=0 during reset and 1 the first cycle after; state=IDLE; cell_x all zeros; all pulses 0; out_valid=0; step_idx=0; busy=0; err=0.
- Acceptance at cycle t: cell_start at t+1. With cell latency L (cell_done at t+1+L), h_load at t+2+L and x_ready at t+3+L.
- Minimum per-step period with x_valid held high: L+3 cycles.
- Last step: head_start one cycle after its h_load. out_valid rises one cycle after head_done.
- DONE→IDLE: x_ready=1 the cycle after the out_ready handshake. A back-to-back sequence costs at least one extra cycle.
- cell_done in the same cycle as cell_start (L=0) is illegal. The cell must respond at least one cycle later.
- Reset asserted mid-sequence: next state is IDLE and all outputs take their reset values. No h_load is issued, and the partial sequence is discarded.

## Configuration
- GRU_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_CELL and WAIT_HEAD.
  - If the count reaches TIMEOUT without the done pulse, err is set (sticky until reset) and the FSM returns to IDLE.
  - No h_load or head_start is issued for that sequence.
- GRU_SEQ_TIMEOUT_EN undefined: no counter; the FSM waits forever; err is tied to 0.

## Test plan
- Nominal: SEQ_LEN=15, cell latency 4, head latency 6, x_valid always high, out_ready high → exactly 15 cell_start, 15 h_load, 1 h_clear and 1 head_start; out_valid high 1 cycle; total 15×7+1+6+1 cycles from first acceptance.
- Input stall: drop x_valid for 10 cycles before step 5 → x_ready stays high, no cell_start issued, step_idx holds 5, completion delayed by exactly 10 cycles.
- Output backpressure: out_ready low for 20 cycles in DONE → out_valid held, x_ready=0, x_valid ignored; handshake then IDLE next cycle.
- Spurious dones: cell_done pulse in IDLE and head_done during WAIT_CELL → no state change, no h_load.
- Reset at step 7 in WAIT_CELL → next cycle busy=0, step_idx=0; a new sequence starts cleanly with h_clear.
- With GRU_SEQ_TIMEOUT_EN and TIMEOUT=50: withhold cell_done → err=1 at cycle 50 of WAIT_CELL, FSM in IDLE, x_ready=1; err persists until reset.

Source files
------------

// File: rtl/gru_seq_ctrl_if.sv
// Handshake and control bundle between the GRU sequencer and its datapath.
// master = sequencer side, slave = environment (input source, cell, head, consumer).
interface gru_seq_ctrl_if #(
  parameter int unsigned X_SIZE = 6,
  parameter int unsigned WIDTH  = 4
);
  logic                    x_valid;
  logic                    x_ready;
  logic signed [WIDTH-1:0] x_data [0:X_SIZE-1];
  logic signed [WIDTH-1:0] cell_x [0:X_SIZE-1];
  logic                    cell_start;
  logic                    cell_done;
  logic                    h_clear;
  logic                    h_load;
  logic                    head_start;
  logic                    head_done;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  x_valid, x_data, cell_done, head_done, out_ready,
    output x_ready, cell_x, cell_start, h_clear, h_load, head_start, out_valid
  );

  modport slave (
    output x_valid, x_data, cell_done, head_done, out_ready,
    input  x_ready, cell_x, cell_start, h_clear, h_load, head_start, out_valid
  );
endinterface

// File: rtl/gru_seq_ctrl.sv
// GRU sequencer: runs the shared cell once per timestep, then the head once per sequence.
// Define GRU_SEQ_TIMEOUT_EN to add the cell/head watchdog and sticky err flag.
module gru_seq_ctrl #(
  parameter int unsigned SEQ_LEN = 15,
  parameter int unsigned X_SIZE  = 6,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  gru_seq_ctrl_if.master             io,
  output logic [$clog2(SEQ_LEN)-1:0] step_idx,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned SW = $clog2(SEQ_LEN);
  localparam logic [SW-1:0] LAST_STEP = SW'(SEQ_LEN - 1);

  if (SEQ_LEN < 2 || X_SIZE < 1 || WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("gru_seq_ctrl: invalid parameterisation");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_CELL, S_LOAD_H, S_ACCEPT, S_HEAD, S_WAIT_HEAD, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] step_nxt;
  logic          capture;
  logic          tmo_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      step_idx <= '0;
    end else begin
      state    <= state_nxt;
      step_idx <= step_nxt;
    end
  end

  // cell_x only moves on an accepted handshake; held through START and the cell run
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < X_SIZE; i++) begin
      if (reset)        io.cell_x[i] <= '0;
      else if (capture) io.cell_x[i] <= io.x_data[i];
    end
  end

  always_comb begin
    state_nxt     = state;
    step_nxt      = step_idx;
    capture       = 1'b0;
    io.x_ready    = 1'b0;
    io.cell_start = 1'b0;
    io.h_clear    = 1'b0;
    io.h_load     = 1'b0;
    io.head_start = 1'b0;
    io.out_valid  = 1'b0;

    case (state)
      S_IDLE: begin
        io.x_ready = 1'b1;
        if (io.x_valid) begin
          capture    = 1'b1;
          io.h_clear = 1'b1;
          step_nxt   = '0;
          state_nxt  = S_START;
        end
      end
      S_START: begin
        io.cell_start = 1'b1;
        state_nxt     = S_WAIT_CELL;
      end
      S_WAIT_CELL: begin
        if (io.cell_done) begin
          state_nxt = S_LOAD_H;
        end else if (tmo_fire) begin
          step_nxt  = '0;
          state_nxt = S_IDLE;
        end
      end
      S_LOAD_H: begin
        io.h_load = 1'b1;
        if (step_idx == LAST_STEP) begin
          state_nxt = S_HEAD;
        end else begin
          step_nxt  = step_idx + 1'b1;
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        io.x_ready = 1'b1;
        if (io.x_valid) begin
          capture   = 1'b1;
          state_nxt = S_START;
        end
      end
      S_HEAD: begin
        io.head_start = 1'b1;
        state_nxt     = S_WAIT_HEAD;
      end
      S_WAIT_HEAD: begin
        if (io.head_done) begin
          state_nxt = S_DONE;
        end else if (tmo_fire) begin
          step_nxt  = '0;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          step_nxt  = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // While reset is held every strobe is forced low, so an in-flight h_load is dropped
    if (reset) begin
      capture       = 1'b0;
      io.x_ready    = 1'b0;
      io.cell_start = 1'b0;
      io.h_clear    = 1'b0;
      io.h_load     = 1'b0;
      io.head_start = 1'b0;
      io.out_valid  = 1'b0;
    end
  end

  assign busy = (state != S_IDLE) && !reset;

`ifdef GRU_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;
  logic          waiting;
  logic          wait_done;

  assign waiting   = (state == S_WAIT_CELL) || (state == S_WAIT_HEAD);
  assign wait_done = ((state == S_WAIT_CELL) && io.cell_done) ||
                     ((state == S_WAIT_HEAD) && io.head_done);
  assign tmo_fire  = waiting && !wait_done && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (waiting && !wait_done && !tmo_fire) ? tmo_cnt + 1'b1 : '0;
      if (tmo_fire) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err      = 1'b0;
`endif

endmodule
